// File: rtl/fetch_queue_mc.sv
// fetch_queue_mc
//
// In-order instruction queue sitting between fetch and dispatch. Each cycle it
// releases up to WAY of its oldest entries to dispatch and then accepts up to
// WAY valid fetch packets into the space that is left, including any space the
// release just freed. Occupancy is tracked with an explicit counter, so DEPTH
// need not be a power of two.
//
// Packet layout (PKT_LEN = INST_LEN + 1 bits per lane):
//   [INST_LEN]     valid
//   [INST_LEN-1:0] instruction word, opcode in bits [6:0]
// Lane i occupies bits [i*PKT_LEN +: PKT_LEN]; lane 0 is the oldest.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous active-high reset
//   flush              squash every entry (mispredict / exception)
//   fetch_in           WAY packets from fetch
//   fetch_accept_num   number of valid fetch_in packets written this cycle
//   disp_num_can_take  max packets dispatch accepts this cycle
//   store_free         free store-queue slots
//   load_free          free load-queue slots
//   branch_free        free branch-tag slots
//   disp_out           released packets, unused lanes all-zero
//   disp_num           number of valid disp_out lanes, contiguous from lane 0
//   disp_store_cnt     stores within disp_out
//   disp_load_cnt      loads within disp_out
//   disp_branch_cnt    branches / jumps within disp_out
//   occupancy          registered entry count
//   free_slots         DEPTH - occupancy

module fetch_queue_mc #(
  parameter int WAY      = 3,
  parameter int DEPTH    = 16,
  parameter int CNT_LEN  = $clog2(WAY + 1),
  parameter int OCC_LEN  = $clog2(DEPTH + 1),
  parameter int INST_LEN = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [WAY*(INST_LEN+1)-1:0]     fetch_in,
  output logic [CNT_LEN-1:0]              fetch_accept_num,
  input  logic [CNT_LEN-1:0]              disp_num_can_take,
  input  logic [CNT_LEN-1:0]              store_free,
  input  logic [CNT_LEN-1:0]              load_free,
  input  logic [CNT_LEN-1:0]              branch_free,
  output logic [WAY*(INST_LEN+1)-1:0]     disp_out,
  output logic [CNT_LEN-1:0]              disp_num,
  output logic [CNT_LEN-1:0]              disp_store_cnt,
  output logic [CNT_LEN-1:0]              disp_load_cnt,
  output logic [CNT_LEN-1:0]              disp_branch_cnt,
  output logic [OCC_LEN-1:0]              occupancy,
  output logic [OCC_LEN-1:0]              free_slots
);

  localparam int PKT_LEN = INST_LEN + 1;
  localparam int IDX_LEN = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    CLS_PLAIN,
    CLS_STORE,
    CLS_LOAD,
    CLS_BRANCH
  } inst_class_e;

  logic [PKT_LEN-1:0] queue [DEPTH];
  logic [IDX_LEN-1:0] head;
  logic [IDX_LEN-1:0] tail;
  logic [OCC_LEN-1:0] count;

  logic [IDX_LEN-1:0] rel_idx   [WAY];
  logic               rel_en    [WAY];
  logic [IDX_LEN-1:0] head_next;

  logic [IDX_LEN-1:0] wr_idx    [WAY];
  logic               wr_en     [WAY];
  logic [PKT_LEN-1:0] wr_data   [WAY];
  logic [IDX_LEN-1:0] tail_next;

  function automatic inst_class_e decode_class(input logic [6:0] opcode);
    case (opcode)
      7'b0100011: return CLS_STORE;
      7'b0000011: return CLS_LOAD;
      7'b1100011,
      7'b1101111,
      7'b1100111: return CLS_BRANCH;
      default:    return CLS_PLAIN;
    endcase
  endfunction

  // Explicit wrap at DEPTH-1 so non-power-of-two depths index correctly.
  function automatic logic [IDX_LEN-1:0] wrap_inc(input logic [IDX_LEN-1:0] idx);
    if (int'(idx) == DEPTH - 1) return '0;
    else                        return idx + 1'b1;
  endfunction

  // Release walk: hand out entries from head in order until dispatch width,
  // queue contents or a class budget runs out. The first entry that cannot go
  // ends the walk so dispatch always sees a strictly in-order prefix. Only
  // registered queue contents are read, so nothing fetched this cycle can
  // bypass straight to dispatch.
  always_comb begin
    int               n_rel;
    int               n_st;
    int               n_ld;
    int               n_br;
    logic             stop;
    logic             fits;
    logic [IDX_LEN-1:0] idx;
    inst_class_e      cls;

    n_rel    = 0;
    n_st     = 0;
    n_ld     = 0;
    n_br     = 0;
    stop     = reset | flush;
    idx      = head;
    disp_out = '0;
    for (int i = 0; i < WAY; i++) begin
      rel_idx[i] = idx;
      rel_en[i]  = 1'b0;
      cls        = decode_class(queue[idx][6:0]);
      case (cls)
        CLS_STORE:  fits = (n_st + 1) <= int'(store_free);
        CLS_LOAD:   fits = (n_ld + 1) <= int'(load_free);
        CLS_BRANCH: fits = (n_br + 1) <= int'(branch_free);
        default:    fits = 1'b1;
      endcase
      if (!stop && (i < int'(disp_num_can_take)) && (i < int'(count)) && fits) begin
        disp_out[i*PKT_LEN +: PKT_LEN] = queue[idx];
        rel_en[i] = 1'b1;
        n_rel++;
        if (cls == CLS_STORE)  n_st++;
        if (cls == CLS_LOAD)   n_ld++;
        if (cls == CLS_BRANCH) n_br++;
        idx = wrap_inc(idx);
      end else begin
        stop = 1'b1;
      end
    end
    head_next       = idx;
    disp_num        = CNT_LEN'(n_rel);
    disp_store_cnt  = CNT_LEN'(n_st);
    disp_load_cnt   = CNT_LEN'(n_ld);
    disp_branch_cnt = CNT_LEN'(n_br);
  end

  // Accept walk: invalid fetch lanes are compacted out, valid lanes are placed
  // at tail while space remains. Space counts the slots released this cycle,
  // so a full queue that releases k entries can take k new ones. The first
  // valid lane that does not fit ends acceptance; fetch replays the rest.
  always_comb begin
    int                 space;
    int                 n_acc;
    logic               stop;
    logic [IDX_LEN-1:0] idx;

    space = DEPTH - int'(count) + int'(disp_num);
    n_acc = 0;
    stop  = reset | flush;
    idx   = tail;
    for (int i = 0; i < WAY; i++) begin
      wr_en[i]   = 1'b0;
      wr_idx[i]  = idx;
      wr_data[i] = fetch_in[i*PKT_LEN +: PKT_LEN];
      if (fetch_in[i*PKT_LEN + INST_LEN]) begin
        if (!stop && (n_acc < space)) begin
          wr_en[i] = 1'b1;
          idx      = wrap_inc(idx);
          n_acc++;
        end else begin
          stop = 1'b1;
        end
      end
    end
    tail_next        = idx;
    fetch_accept_num = CNT_LEN'(n_acc);
  end

  // Queue state. Released slots are cleared first; a write landing in a slot
  // freed this same cycle is issued later in the block and therefore wins.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) queue[e] <= '0;
    end else begin
      for (int i = 0; i < WAY; i++) begin
        if (rel_en[i]) queue[rel_idx[i]] <= '0;
      end
      for (int i = 0; i < WAY; i++) begin
        if (wr_en[i]) queue[wr_idx[i]] <= wr_data[i];
      end
      head  <= head_next;
      tail  <= tail_next;
      count <= count + OCC_LEN'(fetch_accept_num) - OCC_LEN'(disp_num);
    end
  end

  assign occupancy  = count;
  assign free_slots = OCC_LEN'(DEPTH) - count;

endmodule

// File: tb/tb_fetch_queue_mc.sv
// tb_fetch_queue_mc
//
// Drives two fetch_queue_mc instances from the same stimulus: dut_a with
// DEPTH=16 and dut_b with DEPTH=5. Both are compared every cycle against a
// queue-based reference model; a table of vectors and a few hand sequences
// add fixed expected values for the fill / full-release / budget / flush cases.

module tb_fetch_queue_mc;

  localparam int WAY      = 3;
  localparam int INST_LEN = 32;
  localparam int PKT_LEN  = INST_LEN + 1;
  localparam int CNT_LEN  = 2;
  localparam int OCC_A    = 5;
  localparam int OCC_B    = 3;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                     reset;
  logic                     flush;
  logic [WAY*PKT_LEN-1:0]   fetch_in;
  logic [CNT_LEN-1:0]       can_take;
  logic [CNT_LEN-1:0]       store_free;
  logic [CNT_LEN-1:0]       load_free;
  logic [CNT_LEN-1:0]       branch_free;

  logic [CNT_LEN-1:0]       a_accept, a_num, a_st, a_ld, a_br;
  logic [WAY*PKT_LEN-1:0]   a_out;
  logic [OCC_A-1:0]         a_occ, a_free;
  logic [CNT_LEN-1:0]       b_accept, b_num, b_st, b_ld, b_br;
  logic [WAY*PKT_LEN-1:0]   b_out;
  logic [OCC_B-1:0]         b_occ, b_free;

  fetch_queue_mc #(.WAY(WAY), .DEPTH(16)) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .fetch_in(fetch_in),
    .fetch_accept_num(a_accept), .disp_num_can_take(can_take),
    .store_free(store_free), .load_free(load_free), .branch_free(branch_free),
    .disp_out(a_out), .disp_num(a_num), .disp_store_cnt(a_st),
    .disp_load_cnt(a_ld), .disp_branch_cnt(a_br),
    .occupancy(a_occ), .free_slots(a_free)
  );

  fetch_queue_mc #(.WAY(WAY), .DEPTH(5)) dut_b (
    .clock(clock), .reset(reset), .flush(flush), .fetch_in(fetch_in),
    .fetch_accept_num(b_accept), .disp_num_can_take(can_take),
    .store_free(store_free), .load_free(load_free), .branch_free(branch_free),
    .disp_out(b_out), .disp_num(b_num), .disp_store_cnt(b_st),
    .disp_load_cnt(b_ld), .disp_branch_cnt(b_br),
    .occupancy(b_occ), .free_slots(b_free)
  );

  int checks = 0;
  int errors = 0;
  int next_tag = 1;
  logic [31:0] lane_inst [WAY];
  logic [31:0] mq_a [$];
  logic [31:0] mq_b [$];

  typedef struct {
    logic [2:0] mask;
    int         can;
    int         exp_acc;
    int         exp_rel;
    int         exp_occ;
  } vec_t;

  vec_t vecs [10];

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [WAY*PKT_LEN-1:0] act,
                           input logic [WAY*PKT_LEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0 plain, 1 store, 2 load, 3 branch/jump
  function automatic int inst_class(input logic [31:0] inst);
    case (inst[6:0])
      OP_STORE:                return 1;
      OP_LOAD:                 return 2;
      OP_BR, OP_JAL, OP_JALR:  return 3;
      default:                 return 0;
    endcase
  endfunction

  // Reference: release the longest in-order prefix the width and budgets
  // allow, then append valid fetch lanes while the queue has room.
  task automatic model_step(input logic [31:0] q_in [$], input int depth,
                            output logic [31:0] q_out [$], output int rel,
                            output int acc, output int sc, output int lc,
                            output int bc, output logic [WAY*PKT_LEN-1:0] exp_disp);
    logic [31:0] q [$];
    int          room;
    bit          blocked;
    int          c;
    bit          ok;
    q = q_in;
    rel = 0; acc = 0; sc = 0; lc = 0; bc = 0;
    exp_disp = '0;
    if (reset || flush) begin
      q.delete();
      q_out = q;
      return;
    end
    blocked = 0;
    for (int i = 0; i < WAY; i++) begin
      if (blocked || i >= int'(can_take) || i >= q.size()) begin
        blocked = 1;
      end else begin
        c  = inst_class(q[i]);
        ok = 1;
        if (c == 1 && sc + 1 > int'(store_free))  ok = 0;
        if (c == 2 && lc + 1 > int'(load_free))   ok = 0;
        if (c == 3 && bc + 1 > int'(branch_free)) ok = 0;
        if (!ok) blocked = 1;
        else begin
          exp_disp[i*PKT_LEN +: PKT_LEN] = {1'b1, q[i]};
          rel++;
          if (c == 1) sc++;
          if (c == 2) lc++;
          if (c == 3) bc++;
        end
      end
    end
    repeat (rel) void'(q.pop_front());
    room = depth - q.size();
    blocked = 0;
    for (int i = 0; i < WAY; i++) begin
      if (fetch_in[i*PKT_LEN + INST_LEN]) begin
        if (!blocked && room > 0) begin
          q.push_back(fetch_in[i*PKT_LEN +: INST_LEN]);
          acc++;
          room--;
        end else begin
          blocked = 1;
        end
      end
    end
    q_out = q;
  endtask

  task automatic compare_dut(input string who, input int depth,
                             input logic [31:0] q_in [$], output logic [31:0] q_out [$],
                             input int act_acc, input int act_rel, input int act_sc,
                             input int act_lc, input int act_bc,
                             input logic [WAY*PKT_LEN-1:0] act_disp,
                             input int act_occ, input int act_free);
    int rel, acc, sc, lc, bc;
    logic [WAY*PKT_LEN-1:0] exp_disp;
    model_step(q_in, depth, q_out, rel, acc, sc, lc, bc, exp_disp);
    check_int({who, " accept"},   act_acc, acc);
    check_int({who, " disp_num"}, act_rel, rel);
    check_int({who, " store"},    act_sc,  sc);
    check_int({who, " load"},     act_lc,  lc);
    check_int({who, " branch"},   act_bc,  bc);
    check_vec({who, " disp_out"}, act_disp, exp_disp);
    if (!reset) begin
      check_int({who, " occupancy"},  act_occ,  q_in.size());
      check_int({who, " free_slots"}, act_free, depth - q_in.size());
    end
  endtask

  // Drive one cycle of inputs at the falling edge; fresh tagged instructions
  // go on valid lanes, random junk on invalid lanes.
  task automatic apply_stimulus(input logic rst, input logic fl, input logic [2:0] mask,
                                input logic [6:0] op0, input logic [6:0] op1,
                                input logic [6:0] op2, input int can, input int sf,
                                input int lf, input int bf);
    logic [6:0] ops [WAY];
    logic [31:0] inst;
    ops[0] = op0; ops[1] = op1; ops[2] = op2;
    reset       = rst;
    flush       = fl;
    can_take    = CNT_LEN'(can);
    store_free  = CNT_LEN'(sf);
    load_free   = CNT_LEN'(lf);
    branch_free = CNT_LEN'(bf);
    for (int i = 0; i < WAY; i++) begin
      if (mask[i]) begin
        inst = {next_tag[24:0], ops[i]};
        next_tag++;
        lane_inst[i] = inst;
        fetch_in[i*PKT_LEN +: PKT_LEN] = {1'b1, inst};
      end else begin
        lane_inst[i] = '0;
        fetch_in[i*PKT_LEN +: PKT_LEN] = {1'b0, $urandom()};
      end
    end
    #1;
  endtask

  // Compare both instances against the model, then advance one clock.
  task automatic check_output();
    logic [31:0] nqa [$];
    logic [31:0] nqb [$];
    compare_dut("A", 16, mq_a, nqa, int'(a_accept), int'(a_num), int'(a_st),
                int'(a_ld), int'(a_br), a_out, int'(a_occ), int'(a_free));
    compare_dut("B", 5, mq_b, nqb, int'(b_accept), int'(b_num), int'(b_st),
                int'(b_ld), int'(b_br), b_out, int'(b_occ), int'(b_free));
    @(posedge clock);
    mq_a = nqa;
    mq_b = nqb;
    @(negedge clock);
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 6))
      0: return OP_STORE;
      1: return OP_LOAD;
      2: return OP_BR;
      3: return OP_JAL;
      4: return OP_JALR;
      5: return OP_ADD;
      default: return OP_ADDI;
    endcase
  endfunction

  initial begin
    logic [31:0] l0, l2;
    logic [WAY*PKT_LEN-1:0] exp_v;

    vecs[0] = '{3'b111, 0, 3, 0, 0};
    vecs[1] = '{3'b111, 0, 3, 0, 3};
    vecs[2] = '{3'b111, 0, 3, 0, 6};
    vecs[3] = '{3'b111, 0, 3, 0, 9};
    vecs[4] = '{3'b111, 0, 3, 0, 12};
    vecs[5] = '{3'b111, 0, 1, 0, 15};
    vecs[6] = '{3'b111, 0, 0, 0, 16};
    vecs[7] = '{3'b111, 3, 3, 3, 16};
    vecs[8] = '{3'b111, 3, 3, 3, 16};
    vecs[9] = '{3'b000, 0, 0, 0, 16};

    // Reset: outputs held quiet even with valid fetch lanes present.
    for (int r = 0; r < 2; r++) begin
      apply_stimulus(1'b1, 1'b0, 3'b111, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 3);
      check_int("reset accept", int'(a_accept), 0);
      check_output();
    end

    // Fill to full, then release-and-refill at full.
    for (int v = 0; v < 10; v++) begin
      apply_stimulus(1'b0, 1'b0, vecs[v].mask, OP_ADDI, OP_ADDI, OP_ADDI,
                     vecs[v].can, 3, 3, 3);
      check_int($sformatf("vec%0d accept", v),   int'(a_accept), vecs[v].exp_acc);
      check_int($sformatf("vec%0d disp_num", v), int'(a_num),    vecs[v].exp_rel);
      check_int($sformatf("vec%0d occ", v),      int'(a_occ),    vecs[v].exp_occ);
      check_int($sformatf("vec%0d free", v),     int'(a_free),   16 - vecs[v].exp_occ);
      check_output();
    end

    // Drain to 7 entries, then flush.
    for (int d = 0; d < 3; d++) begin
      apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 3);
      check_output();
    end
    apply_stimulus(1'b0, 1'b1, 3'b111, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 3);
    check_int("flush occ", int'(a_occ), 7);
    check_int("flush disp_num", int'(a_num), 0);
    check_int("flush accept", int'(a_accept), 0);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 3);
    check_int("post-flush occ", int'(a_occ), 0);
    check_vec("post-flush disp_out", a_out, '0);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b111, OP_ADDI, OP_ADD, OP_ADDI, 0, 3, 3, 3);
    check_int("post-flush refill", int'(a_accept), 3);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 3);
    check_int("post-flush release", int'(a_num), 3);
    check_output();

    // Store budget throttling: store, store, load with store_free=1.
    apply_stimulus(1'b0, 1'b0, 3'b111, OP_STORE, OP_STORE, OP_LOAD, 0, 3, 3, 3);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 1, 3, 3);
    check_int("ssl1 disp_num", int'(a_num), 1);
    check_int("ssl1 store", int'(a_st), 1);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 1, 3, 3);
    check_int("ssl2 disp_num", int'(a_num), 2);
    check_int("ssl2 load", int'(a_ld), 1);
    check_output();

    // Compaction of fetch lanes {1,0,1}.
    apply_stimulus(1'b0, 1'b0, 3'b101, OP_ADDI, OP_ADDI, OP_ADD, 0, 3, 3, 3);
    l0 = lane_inst[0];
    l2 = lane_inst[2];
    check_int("gap accept", int'(a_accept), 2);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 3);
    exp_v = '0;
    exp_v[0 +: PKT_LEN]       = {1'b1, l0};
    exp_v[PKT_LEN +: PKT_LEN] = {1'b1, l2};
    check_int("gap disp_num", int'(a_num), 2);
    check_vec("gap disp_out", a_out, exp_v);
    check_output();

    // Zero branch budget blocks a branch at head and everything behind it.
    apply_stimulus(1'b0, 1'b0, 3'b111, OP_JAL, OP_ADDI, OP_ADDI, 0, 3, 3, 3);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 0);
    check_int("br0 disp_num", int'(a_num), 0);
    check_output();
    apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 1);
    check_int("br1 disp_num", int'(a_num), 3);
    check_int("br1 branch", int'(a_br), 1);
    check_output();

    // Sustained stream through the DEPTH=5 instance, wrapping repeatedly.
    for (int s = 0; s < 20; s++) begin
      apply_stimulus(1'b0, 1'b0, 3'b111, OP_ADDI, OP_ADD, OP_ADDI, 2, 3, 3, 3);
      check_output();
    end
    for (int s = 0; s < 8; s++) begin
      apply_stimulus(1'b0, 1'b0, 3'b000, OP_ADDI, OP_ADDI, OP_ADDI, 3, 3, 3, 3);
      check_output();
    end
    check_int("stream drained B", int'(b_occ), 0);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                     3'($urandom_range(0, 7)), rand_op(), rand_op(), rand_op(),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
      check_output();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
